mdu_hilo: RTL and testbench
===========================

# mdu_hilo

Iterative multiply/divide unit with the architectural HI/LO register pair. Sits in the EX stage beside the ALU and takes the same `inA`/`inB` operands. Executes MULT, MULTU, DIV, DIVU as multi-cycle operations and MTHI/MTLO as single-cycle writes. Raises `busy` so the hazard logic can stall any MFHI/MFLO or new MDU instruction.

## Interface
- `WORD_WIDTH`, default 32: operand and HI/LO width. Must be even and ≥4.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request. Sampled only when `busy`=0.
- `op`  in  3: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (acts as NOP).
- `inA`  in  WORD_WIDTH: rs operand (multiplicand, dividend, or MTHI/MTLO data).
- `inB`  in  WORD_WIDTH: rt operand (multiplier or divisor).
- `cancel`  in  1: pipeline flush. Aborts any operation in flight.
- `busy`  out  1: high while a multi-cycle operation is in progress.
- `done`  out  1: one-cycle pulse when HI/LO have just been updated.
- `hi`  out  WORD_WIDTH: HI register.
- `lo`  out  WORD_WIDTH: LO register.

## Operation
- States:
  - IDLE
  - CALC: W = WORD_WIDTH iterations. A down-counter loads W-1 and moves to FIX when it is 0.
  - FIX: sign correction, then HI/LO write.
- `busy` = (state != IDLE).
- IDLE with `start`=1 and `cancel`=0:
  - MULT/MULTU/DIV/DIVU: latch the operands into internal registers and go to CALC. `inA`/`inB` may change afterwards with no effect.
  - MTHI: `hi` <= `inA` at that edge. MTLO: `lo` <= `inA`. State stays IDLE and `done` pulses the next cycle.
  - NOP/reserved: no effect and no `done`.
- Signed ops (MULT, DIV): operands are converted to magnitudes before CALC, and the negation flags are stored.
- Multiply: shift-add over a 2W-bit product register, one multiplier bit per CALC cycle.
  - FIX negates the product if signA^signB.
  - HI = product[2W-1:W], LO = product[W-1:0].
- Divide: restoring division, one quotient bit per CALC cycle, on a W+1-bit partial remainder.
  - FIX negates the quotient if signA^signB and negates the remainder if signA.
  - LO = quotient, HI = remainder.
- Divide-by-zero is defined and not trapped. It is the natural algorithm result:
  - DIVU: LO = all ones, HI = `inA`.
  - DIV: LO = (inA<0 ? 1 : all ones), HI = `inA`.
- DIV of most-negative by -1: LO = 1000…0, HI = 0.
- `start` while `busy`=1 is ignored. The issuer is responsible for stalling.
- `cancel`=1 in any state: next state is IDLE, and the internal datapath is discarded.
  - `hi`/`lo` keep their pre-operation values and no `done` is issued.
  - `cancel` has priority over a simultaneous `start` in IDLE.
  - A `cancel` in FIX also suppresses the HI/LO write.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state = IDLE, counter = 0.
  - `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0. Internal operand and product registers are cleared.
  - Reset asserted mid-operation loses the operation and produces no `done`.
- Multi-cycle op, with `start` sampled at the end of cycle 0:
  - `busy`=1 in cycles 1..W+1 (W CALC cycles, then 1 FIX cycle).
  - Cycle W+2: `hi`/`lo` hold the new values, `done`=1 for that cycle only, `busy`=0.
  - Total latency W+2 (34 for W=32).
- A new `start` is accepted in cycle W+2, the same cycle as `done`, so back-to-back operations have no bubble.
- MTHI/MTLO: register updated at the end of cycle 0, `done`=1 in cycle 1, `busy` never asserted.
- `done`, `busy`, `hi` and `lo` are all registered outputs with no combinational path from the inputs.

## Test plan
- MULTU FFFFFFFF × FFFFFFFF -> `done` exactly 34 cycles after the start edge, HI=FFFFFFFE, LO=00000001. `busy` is high for exactly 33 cycles.
- MULT -3 × 5 -> HI=FFFFFFFF, LO=FFFFFFF1. MULT 80000000 × 80000000 -> HI=40000000, LO=00000000.
- DIV -7 / 2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIVU 7 / 0 -> LO=FFFFFFFF, HI=00000007. DIV 80000000 / FFFFFFFF -> LO=80000000, HI=0.
- MTHI 12345678, then MTLO 9ABCDEF0 on consecutive cycles -> `done` pulses in cycles 1 and 2, and HI/LO hold those values.
- Pulse `start` with DIVU 100/3 during `busy` of an earlier op -> the second request is ignored, the first op's result is written, and exactly one `done` occurs.
- MULTU 2×3, then `cancel` in CALC cycle 10 -> `busy` drops the next cycle, HI/LO are unchanged, no `done`. Repeat with `rst_n` low in FIX -> HI=LO=0 and no `done`.

Source files
------------

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit holding the architectural HI/LO pair.
// MULT/MULTU/DIV/DIVU take WORD_WIDTH CALC cycles plus one FIX cycle;
// MTHI/MTLO write HI/LO in a single cycle.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, sampled only while busy = 0
//   op      000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NOP
//   inA     rs operand (multiplicand, dividend, MTHI/MTLO data)
//   inB     rt operand (multiplier, divisor)
//   cancel  pipeline flush, aborts any operation in flight
//   busy    multi-cycle operation in progress
//   done    one-cycle pulse after HI/LO were updated
//   hi, lo  HI and LO registers
module mdu_hilo #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [WORD_WIDTH-1:0] inA,
  input  logic [WORD_WIDTH-1:0] inB,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] hi,
  output logic [WORD_WIDTH-1:0] lo
);

  localparam int W  = WORD_WIDTH;
  localparam int CW = $clog2(WORD_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  state_t        state, state_next;
  op_t           op_dec;
  logic [CW-1:0] count;

  // acc: upper product half (multiply) or partial remainder (divide).
  // qr:  multiplier shifting out / dividend shifting out, quotient shifting in.
  // opb: multiplicand magnitude or divisor magnitude.
  logic [W-1:0]  acc, qr, opb;
  logic          is_div, neg_res, neg_rem;

  logic          accept, is_long, is_signed;
  logic          sign_a, sign_b;
  logic [W-1:0]  abs_a, abs_b;

  logic [W:0]    mul_sum;
  logic [W:0]    div_shift;
  logic [W-1:0]  div_diff;
  logic          div_ge;

  logic [2*W-1:0] fix_prod;
  logic [W-1:0]   fix_q, fix_r;

  assign op_dec    = op_t'(op);
  assign accept    = (state == S_IDLE) && start && !cancel;
  assign is_long   = (op_dec == OP_MULT) || (op_dec == OP_MULTU) ||
                     (op_dec == OP_DIV)  || (op_dec == OP_DIVU);
  assign is_signed = (op_dec == OP_MULT) || (op_dec == OP_DIV);
  assign sign_a    = is_signed && inA[W-1];
  assign sign_b    = is_signed && inB[W-1];
  assign abs_a     = sign_a ? (~inA + 1'b1) : inA;
  assign abs_b     = sign_b ? (~inB + 1'b1) : inB;
  assign busy      = (state != S_IDLE);

  always_comb begin
    // Multiply step: conditionally add multiplicand, then shift product right.
    mul_sum   = {1'b0, acc} + (qr[0] ? {1'b0, opb} : '0);
    // Restoring divide step on a W+1-bit partial remainder. When the trial
    // subtraction succeeds the result is below the divisor, so its low W bits
    // are exact and the partial remainder register only needs W bits.
    div_shift = {acc, qr[W-1]};
    div_ge    = (div_shift >= {1'b0, opb});
    div_diff  = div_shift[W-1:0] - opb;
    fix_prod  = {acc, qr};
    if (neg_res) fix_prod = ~fix_prod + 1'b1;
    fix_q     = neg_res ? (~qr + 1'b1) : qr;
    fix_r     = neg_rem ? (~acc + 1'b1) : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (accept && is_long) state_next = S_CALC;
      S_CALC: if (count == '0)       state_next = S_FIX;
      S_FIX:                         state_next = S_IDLE;
      default:                       state_next = S_IDLE;
    endcase
    if (cancel) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      acc     <= '0;
      qr      <= '0;
      opb     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        unique case (op_dec)
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            count   <= CW'(W - 1);
            acc     <= '0;
            is_div  <= (op_dec == OP_DIV) || (op_dec == OP_DIVU);
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            if ((op_dec == OP_DIV) || (op_dec == OP_DIVU)) begin
              qr  <= abs_a;
              opb <= abs_b;
            end else begin
              qr  <= abs_b;
              opb <= abs_a;
            end
          end
          OP_MTHI: begin
            hi   <= inA;
            done <= 1'b1;
          end
          OP_MTLO: begin
            lo   <= inA;
            done <= 1'b1;
          end
          default: ;
        endcase
      end else if (state == S_CALC && !cancel) begin
        if (count != '0) count <= count - 1'b1;
        if (is_div) begin
          acc <= div_ge ? div_diff : div_shift[W-1:0];
          qr  <= {qr[W-2:0], div_ge};
        end else begin
          acc <= mul_sum[W:1];
          qr  <= {mul_sum[0], qr[W-1:1]};
        end
      end else if (state == S_FIX && !cancel) begin
        if (is_div) begin
          lo <= fix_q;
          hi <= fix_r;
        end else begin
          hi <= fix_prod[2*W-1:W];
          lo <= fix_prod[W-1:0];
        end
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Testbench for mdu_hilo (WORD_WIDTH = 32): table of directed multiply/divide
// vectors with hand-computed HI/LO, plus MTHI/MTLO, ignored-start, cancel and
// reset-in-FIX sequences.
module tb_mdu_hilo;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] inA, inB;
  logic         cancel;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int unsigned errors = 0;
  int unsigned checks = 0;

  mdu_hilo #(.WORD_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .inA(inA), .inB(inB),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1 of cycle 0; returns at posedge+1 of the done cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int unsigned cyc, bcnt;
    op = v.op; inA = v.a; inB = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0; inA = $urandom; inB = $urandom;
    chk($sformatf("v%0d done_low_cycle1", idx), {31'd0, done}, 32'd0);
    cyc = 1; bcnt = 0;
    while (!done && cyc < 200) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("v%0d latency", idx), cyc, 32'd34);
    chk($sformatf("v%0d busy_cycles", idx), bcnt, 32'd33);
    chk($sformatf("v%0d busy_at_done", idx), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d hi", idx), hi, v.exp_hi);
    chk($sformatf("v%0d lo", idx), lo, v.exp_lo);
  endtask

  initial begin
    int unsigned ndone;

    vecs[0] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001}; // MULTU
    vecs[1] = '{3'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1}; // MULT -3*5
    vecs[2] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000}; // MULT
    vecs[3] = '{3'd2, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780}; // MULTU
    vecs[4] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD}; // DIV -7/2
    vecs[5] = '{3'd4, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF}; // DIVU 7/0
    vecs[6] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000}; // DIV min/-1
    vecs[7] = '{3'd3, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'h00000001}; // DIV -8/0
    vecs[8] = '{3'd4, 32'd100,      32'd3,        32'h00000001, 32'h00000021}; // DIVU 100/3
    vecs[9] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD}; // DIV 7/-2

    rst_n = 1'b0; start = 1'b0; op = 3'd0; inA = '0; inB = '0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; op = 3'd5; inA = 32'h12345678;
    @(posedge clk); #1;
    op = 3'd6; inA = 32'h9ABCDEF0;
    chk("mthi done c1", {31'd0, done}, 32'd1);
    chk("mthi busy c1", {31'd0, busy}, 32'd0);
    chk("mthi hi", hi, 32'h12345678);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0; inA = '0;
    chk("mtlo done c2", {31'd0, done}, 32'd1);
    chk("mtlo busy c2", {31'd0, busy}, 32'd0);
    chk("mtlo lo", lo, 32'h9ABCDEF0);
    chk("mtlo hi kept", hi, 32'h12345678);
    @(posedge clk); #1;
    chk("mt done c3", {31'd0, done}, 32'd0);

    // cancel wins over start in IDLE
    start = 1'b1; cancel = 1'b1; op = 3'd5; inA = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; op = 3'd0;
    chk("cancel_idle done", {31'd0, done}, 32'd0);
    chk("cancel_idle hi", hi, 32'h12345678);

    // table, issued back-to-back (next start in the done cycle)
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
    @(posedge clk); #1;
    chk("last done width", {31'd0, done}, 32'd0);

    // start during busy is ignored
    start = 1'b1; op = 3'd1; inA = 32'hFFFFFFFD; inB = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 3'd4; inA = 32'd100; inB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    ndone = 0;
    for (int c = 0; c < 80; c++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("ignored_start dones", ndone, 32'd1);
    chk("ignored_start hi", hi, 32'hFFFFFFFF);
    chk("ignored_start lo", lo, 32'hFFFFFFF1);
    chk("ignored_start busy", {31'd0, busy}, 32'd0);

    // cancel in CALC cycle 10
    start = 1'b1; op = 3'd2; inA = 32'd2; inB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    repeat (9) @(posedge clk);
    #1;
    chk("cancel busy c10", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel busy c11", {31'd0, busy}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("cancel dones", ndone, 32'd0);
    chk("cancel hi", hi, 32'hFFFFFFFF);
    chk("cancel lo", lo, 32'hFFFFFFF1);

    // reset asserted in FIX (cycle 33)
    start = 1'b1; op = 3'd2; inA = 32'd2; inB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    repeat (32) @(posedge clk);
    #1;
    chk("fix busy c33", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_fix busy", {31'd0, busy}, 32'd0);
    chk("rst_fix hi", hi, 32'd0);
    chk("rst_fix lo", lo, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("rst_fix dones", ndone, 32'd0);
    chk("rst_fix hi after", hi, 32'd0);
    chk("rst_fix lo after", lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
